// File: rtl/plru_tree_pkg.sv
// rtl/plru_tree_pkg.sv - shared helpers for the tree pseudo-LRU replacement block
//
// Purpose: index-width helper and heap-order node arithmetic used by
//          plru_tree and plru_tree_pick.
// Ports:   none (package).
package plru_tree_pkg;

  // Heap layout: node 0 is the root, node i has children 2i+1 (lower half)
  // and 2i+2 (upper half).
  localparam int HEAP_ROOT    = 0;
  localparam int CHILD_LO_OFS = 1;
  localparam int CHILD_HI_OFS = 2;

  // Width of an index selecting one of n items; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int child_lo(input int i);
    return 2 * i + CHILD_LO_OFS;
  endfunction

  function automatic int child_hi(input int i);
    return 2 * i + CHILD_HI_OFS;
  endfunction

  function automatic int parent(input int i);
    return (i - CHILD_LO_OFS) / 2;
  endfunction

endpackage

// File: rtl/plru_tree_pick.sv
// rtl/plru_tree_pick.sv - combinational victim selection for one PLRU tree
//
// Purpose: picks the lowest-index invalid eligible way if one exists,
//          otherwise walks the tree from the root, steering around
//          subtrees that contain no eligible way.
// Ports:   tree_i   - WAYS-1 node bits of the set being allocated
//          elig_i   - per-way eligibility (1 = may be chosen)
//          valid_i  - per-way line-valid bits
//          onehot_o - chosen way, one-hot
//          idx_o    - chosen way, binary
// Result is meaningless when elig_i is all zero; the caller gates it.
module plru_tree_pick
  import plru_tree_pkg::*;
#(
  parameter int WAYS = 32
) (
  input  logic [WAYS-2:0]             tree_i,
  input  logic [WAYS-1:0]             elig_i,
  input  logic [WAYS-1:0]             valid_i,
  output logic [WAYS-1:0]             onehot_o,
  output logic [idx_width(WAYS)-1:0]  idx_o
);

  localparam int IW    = idx_width(WAYS);
  localparam int NODES = 2 * WAYS - 1;

  always_comb begin
    // Leaves occupy heap slots WAYS-1 .. 2*WAYS-2 so the same child
    // arithmetic reaches them from the last internal level.
    logic [NODES-1:0] any_elig;
    logic [WAYS-1:0]  free_elig;
    logic             found;
    int               first;
    int               node;
    int               sel;
    int               alt;

    any_elig  = '0;
    free_elig = ~valid_i & elig_i;
    found     = 1'b0;
    first     = 0;
    node      = HEAP_ROOT;
    sel       = 0;
    alt       = 0;

    for (int w = 0; w < WAYS; w++) begin
      any_elig[WAYS-1+w] = elig_i[w];
    end
    for (int i = WAYS - 2; i >= 0; i--) begin
      any_elig[i] = any_elig[child_lo(i)] | any_elig[child_hi(i)];
    end

    for (int w = 0; w < WAYS; w++) begin
      if (!found && free_elig[w]) begin
        found = 1'b1;
        first = w;
      end
    end

    for (int d = 0; d < IW; d++) begin
      sel  = tree_i[node] ? child_hi(node) : child_lo(node);
      alt  = tree_i[node] ? child_lo(node) : child_hi(node);
      node = any_elig[sel] ? sel : alt;
    end

    idx_o           = found ? IW'(first) : IW'(node - (WAYS - 1));
    onehot_o        = '0;
    onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - per-set tree pseudo-LRU state with hit and allocation update
//
// Purpose: holds SETS independent trees of WAYS-1 bits, reports the victim
//          for an allocation combinationally and updates the trees on the
//          clock edge. Build option PLRU_LOCK_EN adds lock_mask.
// Ports:   clk, rst_n          - clock, asynchronous active-low reset
//          hit/hit_set/hit_sel - hit update (one-hot way)
//          plru_wen/alloc_set/valid_mask - allocation request
//          flush               - synchronous clear of every tree
//          lock_mask           - (PLRU_LOCK_EN only) 1 = way not replaceable
//          wen/victim_idx      - victim one-hot / binary
//          victim_none         - allocation with no eligible way
module plru_tree
  import plru_tree_pkg::*;
#(
  parameter int WAYS = 32,
  parameter int SETS = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        hit,
  input  logic [idx_width(SETS)-1:0]  hit_set,
  input  logic [WAYS-1:0]             hit_sel,
  input  logic                        plru_wen,
  input  logic [idx_width(SETS)-1:0]  alloc_set,
  input  logic [WAYS-1:0]             valid_mask,
  input  logic                        flush,
`ifdef PLRU_LOCK_EN
  input  logic [WAYS-1:0]             lock_mask,
`endif
  output logic [WAYS-1:0]             wen,
  output logic [$clog2(WAYS)-1:0]     victim_idx,
  output logic                        victim_none
);

  localparam int IW = idx_width(WAYS);
  localparam int SW = idx_width(SETS);

  logic [WAYS-2:0] tree_q [SETS];
  logic [WAYS-2:0] tree_d [SETS];
  logic [WAYS-2:0] alloc_cur, hit_cur;
  logic [WAYS-2:0] alloc_next, hit_next;
  logic [WAYS-1:0] elig;
  logic [WAYS-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   hit_idx;
  logic            can_alloc;
  logic            alloc_do;
  logic            hit_do;

`ifdef PLRU_LOCK_EN
  assign elig = ~lock_mask;
`else
  assign elig = '1;
`endif

  // Make every node on way w's path point at the opposite half. At depth d
  // the node is (2^d - 1) + (w >> (IW-d)) and w[IW-1-d] is the side taken.
  function automatic logic [WAYS-2:0] point_away(input logic [WAYS-2:0] t,
                                                 input logic [IW-1:0]   w);
    logic [WAYS-2:0] r;
    r = t;
    for (int d = 0; d < IW; d++) begin
      r[(1 << d) - 1 + int'(w >> (IW - d))] = ~w[IW-1-d];
    end
    return r;
  endfunction

  always_comb begin
    alloc_cur = tree_q[0];
    hit_cur   = tree_q[0];
    for (int s = 0; s < SETS; s++) begin
      if (alloc_set == SW'(s)) alloc_cur = tree_q[s];
      if (hit_set == SW'(s))   hit_cur   = tree_q[s];
    end
  end

  plru_tree_pick #(.WAYS(WAYS)) u_pick (
    .tree_i   (alloc_cur),
    .elig_i   (elig),
    .valid_i  (valid_mask),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

  assign can_alloc   = |elig;
  assign alloc_do    = plru_wen & can_alloc;
  assign victim_none = plru_wen & ~can_alloc;
  assign wen         = alloc_do ? pick_onehot : '0;
  assign victim_idx  = alloc_do ? pick_idx : '0;

  always_comb begin
    hit_idx = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_sel[w]) hit_idx = IW'(w);
    end
  end

  assign hit_do     = hit & (|hit_sel);
  assign alloc_next = point_away(alloc_cur, pick_idx);
  assign hit_next   = point_away(hit_cur, hit_idx);

  // Allocation wins over a hit to the same set; different sets both update.
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      tree_d[s] = tree_q[s];
      if (flush) begin
        tree_d[s] = '0;
      end else if (alloc_do && (SETS == 1 || alloc_set == SW'(s))) begin
        tree_d[s] = alloc_next;
      end else if (hit_do && (SETS == 1 || hit_set == SW'(s))) begin
        tree_d[s] = hit_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= tree_d[s];
    end
  end

endmodule
